// File: rtl/bank_dump_printer.sv
// bank_dump_printer: walks an index range of a flat word bank and
// hands one {prefix, stamp, index, word} frame per word to the UART writer.
module bank_dump_printer #(
  parameter int UART_BUS_SIZE = 8,
  parameter int WORD_SIZE = 32,
  parameter int NUM_WORDS = 32,
  parameter logic [UART_BUS_SIZE-1:0] PREFIX = 8'hFF,
  localparam int IDX_W = $clog2(NUM_WORDS),
  localparam int OUT_W = 3*UART_BUS_SIZE + WORD_SIZE
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic                           i_skip_zero,
  input  logic [IDX_W-1:0]               i_first,
  input  logic [IDX_W-1:0]               i_last,
  input  logic [NUM_WORDS*WORD_SIZE-1:0] i_bank,
  input  logic [UART_BUS_SIZE-1:0]       i_clk_cicle,
  input  logic                           i_wr_end,
  output logic                           o_start_wr,
  output logic [OUT_W-1:0]               o_data_wr,
  output logic                           o_busy,
  output logic                           o_end,
  output logic                           o_aborted,
  output logic [IDX_W:0]                 o_frames
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_WORDS-1);
  localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT_TRANS,
    S_WAIT_WR,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W:0]           ptr_q, ptr_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic                     skip_q, skip_d;
  logic [UART_BUS_SIZE-1:0] stamp_q, stamp_d;
  logic                     abort_q, abort_d;
  logic                     aborted_q, aborted_d;
  logic [IDX_W:0]           frames_q, frames_d;
  logic                     start_q, start_d;
  logic                     end_q, end_d;
  logic [OUT_W-1:0]         data_q, data_d;

  logic [WORD_SIZE-1:0]     word_cur;
  logic [UART_BUS_SIZE-1:0] idx_ext;
  logic [IDX_W-1:0]         eff_last;
  logic                     past_end;
  logic                     abort_now;
  logic                     skip_cur;

  // select the live bank word under the pointer (zero past the bank)
  always_comb begin
    word_cur = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (ptr_q == (IDX_W+1)'(k)) begin
        word_cur = i_bank[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // scan-step qualifiers shared by next-state and datapath
  always_comb begin
    eff_last  = (i_last > MAX_IDX) ? MAX_IDX : i_last;
    past_end  = ptr_q > {1'b0, last_q};
    abort_now = abort_q | i_abort;
    skip_cur  = skip_q && (word_cur == '0);
    idx_ext   = '0;
    idx_ext[IDX_W-1:0] = ptr_q[IDX_W-1:0];
  end

  // state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (abort_now)     state_d = S_DONE;
        else if (past_end) state_d = S_DONE;
        else if (skip_cur) state_d = S_SCAN;
        else               state_d = S_ISSUE;
      end
      S_ISSUE:      state_d = S_WAIT_TRANS;
      S_WAIT_TRANS: state_d = S_WAIT_WR;
      S_WAIT_WR: begin
        if (i_wr_end) state_d = S_SCAN;
      end
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // datapath / output next values
  always_comb begin
    ptr_d     = ptr_q;
    last_d    = last_q;
    skip_d    = skip_q;
    stamp_d   = stamp_q;
    abort_d   = abort_q;
    aborted_d = aborted_q;
    frames_d  = frames_q;
    data_d    = data_q;
    start_d   = 1'b0;
    end_d     = (state_d == S_DONE);
    if (state_q != S_IDLE && i_abort) abort_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          ptr_d     = {1'b0, i_first};
          last_d    = eff_last;
          skip_d    = i_skip_zero;
          stamp_d   = i_clk_cicle;
          abort_d   = 1'b0;
          aborted_d = 1'b0;
          frames_d  = '0;
        end
      end
      S_SCAN: begin
        if (abort_now) begin
          aborted_d = 1'b1;
        end else if (!past_end && skip_cur) begin
          ptr_d = ptr_q + ONE;
        end
      end
      S_ISSUE: begin
        data_d   = {PREFIX, stamp_q, idx_ext, word_cur};
        start_d  = 1'b1;
        frames_d = frames_q + ONE;
        ptr_d    = ptr_q + ONE;
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ptr_q     <= '0;
      last_q    <= '0;
      skip_q    <= 1'b0;
      stamp_q   <= '0;
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
      frames_q  <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      skip_q    <= skip_d;
      stamp_q   <= stamp_d;
      abort_q   <= abort_d;
      aborted_q <= aborted_d;
      frames_q  <= frames_d;
      start_q   <= start_d;
      end_q     <= end_d;
      data_q    <= data_d;
    end
  end

  // output drive
  always_comb begin
    o_start_wr = start_q;
    o_data_wr  = data_q;
    o_busy     = (state_q != S_IDLE);
    o_end      = end_q;
    o_aborted  = aborted_q;
    o_frames   = frames_q;
  end

endmodule

// File: tb/tb_bank_dump_printer.sv
// tb_bank_dump_printer: table vectors, hand sequences and random dumps
// checked against a list-of-frames reference model.
module tb_bank_dump_printer;

  localparam int NW = 32;
  localparam int WS = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 0, i_abort = 0, i_skip_zero = 0;
  logic [4:0]    i_first = 0, i_last = 0;
  logic [NW*WS-1:0] i_bank = '0;
  logic [7:0]    i_clk_cicle = 0;
  logic          i_wr_end = 0;
  logic          o_start_wr, o_busy, o_end, o_aborted;
  logic [55:0]   o_data_wr;
  logic [5:0]    o_frames;

  always #5 clk = ~clk;

  bank_dump_printer dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(i_start),
    .i_abort(i_abort), .i_skip_zero(i_skip_zero),
    .i_first(i_first), .i_last(i_last), .i_bank(i_bank),
    .i_clk_cicle(i_clk_cicle), .i_wr_end(i_wr_end),
    .o_start_wr(o_start_wr), .o_data_wr(o_data_wr),
    .o_busy(o_busy), .o_end(o_end), .o_aborted(o_aborted),
    .o_frames(o_frames)
  );

  int passed = 0;
  int total = 0;
  logic [31:0] bank_w [NW];
  logic [55:0] got[$];
  logic [55:0] exp_q[$];
  int end_cnt = 0;
  int pend = 0;

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    logic       sk;
    logic [7:0] st;
    int         pat;
    int         exp_n;
    int         exp_first;
    int         exp_end;
  } vec_t;

  vec_t tbl[7];

  // frame monitor
  always @(negedge clk) begin
    if (o_start_wr) got.push_back(o_data_wr);
    if (o_end) end_cnt++;
  end

  // writer model: ack 4 cycles after each start pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
      i_wr_end = 0;
    end else begin
      i_wr_end = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) i_wr_end = 1;
      end
      if (o_start_wr) pend = 4;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_pat(input int p);
    for (int k = 0; k < NW; k++) begin
      case (p)
        0: bank_w[k] = 32'hC0DE_0000 + k;
        1: bank_w[k] = k + 100;
        2: bank_w[k] = (k == 3) ? 32'h1234_5678 :
                       (k == 30) ? 32'h8000_0001 : 32'h0;
        3: bank_w[k] = 32'h0;
        default: bank_w[k] = (k % 3 == 0) ? 32'h0 : k + 1;
      endcase
      i_bank[k*WS +: WS] = bank_w[k];
    end
  endtask

  // reference: frames implied by range, clamp and skip rules
  task automatic build_exp(input int f, input int l, input bit sk,
                           input logic [7:0] st);
    int hi;
    exp_q.delete();
    hi = (l > NW-1) ? NW-1 : l;
    for (int k = f; k <= hi; k++) begin
      if (!(sk && bank_w[k] == 0))
        exp_q.push_back({8'hFF, st, 8'(k), bank_w[k]});
    end
  endtask

  task automatic run(input logic [4:0] f, input logic [4:0] l,
                     input logic sk, input logic [7:0] st,
                     input int abort_at, output int first_j,
                     output int end_j, output logic busy2);
    int sc = 0;
    int ab = 0;
    first_j = -1;
    end_j = -1;
    busy2 = 0;
    @(negedge clk);
    got.delete();
    end_cnt = 0;
    i_first = f;
    i_last = l;
    i_skip_zero = sk;
    i_clk_cicle = st;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    for (int j = 2; j < 3000; j++) begin
      @(negedge clk);
      i_abort = 0;
      if (ab == 1) begin
        i_abort = 1;
        ab = 0;
      end
      if (j == 2) busy2 = o_busy;
      if (o_start_wr) begin
        if (first_j < 0) first_j = j;
        sc++;
        if (sc == abort_at + 1) ab = 1;
      end
      if (o_end) begin
        end_j = j;
        break;
      end
    end
    repeat (3) @(negedge clk);
    chk("end_seen", 64'(end_j >= 0), 1);
  endtask

  task automatic compare(input string tag, input int exp_n,
                         input bit ab);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_n));
    chk({tag, "_frames"}, 64'(o_frames), 64'(exp_n));
    chk({tag, "_aborted"}, 64'(o_aborted), 64'(ab));
    chk({tag, "_endcnt"}, 64'(end_cnt), 1);
    chk({tag, "_idle"}, 64'(o_busy), 0);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_frame%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int fj, ej;
    logic b2;
    logic [4:0] rf, rl;
    logic rs;
    logic [7:0] rst_v;

    tbl[0] = '{5'd0,  5'd31, 1'b0, 8'h2A, 0, 32, 3, -1};
    tbl[1] = '{5'd5,  5'd7,  1'b0, 8'h11, 1, 3, 3, -1};
    tbl[2] = '{5'd0,  5'd31, 1'b1, 8'h33, 2, 2, -1, -1};
    tbl[3] = '{5'd9,  5'd4,  1'b0, 8'h44, 1, 0, -1, 2};
    tbl[4] = '{5'd31, 5'd31, 1'b0, 8'h55, 1, 1, 3, -1};
    tbl[5] = '{5'd0,  5'd31, 1'b1, 8'h66, 3, 0, -1, 34};
    tbl[6] = '{5'd2,  5'd31, 1'b1, 8'h77, 4, 20, -1, -1};

    repeat (3) @(negedge clk);
    chk("rst_start", 64'(o_start_wr), 0);
    chk("rst_data", 64'(o_data_wr), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_end", 64'(o_end), 0);
    chk("rst_abt", 64'(o_aborted), 0);
    chk("rst_frm", 64'(o_frames), 0);
    rst_n = 1;

    @(negedge clk);
    i_abort = 1;
    @(negedge clk);
    i_abort = 0;

    for (int i = 0; i < 7; i++) begin
      set_pat(tbl[i].pat);
      build_exp(tbl[i].f, tbl[i].l, tbl[i].sk, tbl[i].st);
      run(tbl[i].f, tbl[i].l, tbl[i].sk, tbl[i].st, -1, fj, ej, b2);
      compare($sformatf("vec%0d", i), tbl[i].exp_n, 0);
      chk($sformatf("vec%0d_busy", i), 64'(b2), 1);
      if (tbl[i].exp_first >= 0)
        chk($sformatf("vec%0d_lat", i), 64'(fj), 64'(tbl[i].exp_first));
      if (tbl[i].exp_end >= 0)
        chk($sformatf("vec%0d_endlat", i), 64'(ej), 64'(tbl[i].exp_end));
      if (tbl[i].exp_n == 0)
        chk($sformatf("vec%0d_nostart", i), 64'(fj), 64'(-1));
    end

    set_pat(0);
    build_exp(0, 2, 0, 8'h5A);
    run(5'd0, 5'd10, 1'b0, 8'h5A, 2, fj, ej, b2);
    compare("abort", 3, 1);

    set_pat(0);
    @(negedge clk);
    i_first = 0;
    i_last = 31;
    i_skip_zero = 0;
    i_clk_cicle = 8'h01;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    fj = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (o_start_wr) begin
        fj = j;
        break;
      end
    end
    chk("mid_pulse", 64'(fj >= 0), 1);
    #2 rst_n = 0;
    #1;
    chk("mid_start", 64'(o_start_wr), 0);
    chk("mid_busy", 64'(o_busy), 0);
    chk("mid_data", 64'(o_data_wr), 0);
    chk("mid_frm", 64'(o_frames), 0);
    @(negedge clk);
    #2 rst_n = 1;
    set_pat(1);
    build_exp(4, 6, 0, 8'h9C);
    run(5'd4, 5'd6, 1'b0, 8'h9C, -1, fj, ej, b2);
    compare("after_rst", 3, 0);

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < NW; k++) begin
        bank_w[k] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
        i_bank[k*WS +: WS] = bank_w[k];
      end
      rf = 5'($urandom_range(0, 31));
      rl = 5'($urandom_range(0, 31));
      rs = 1'($urandom_range(0, 1));
      rst_v = 8'($urandom);
      build_exp(rf, rl, rs, rst_v);
      run(rf, rl, rs, rst_v, -1, fj, ej, b2);
      compare($sformatf("rnd%0d", r), exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
